// File: rtl/rename_map_lifo_if.sv
// Rename/commit/flush handshake bundle between decode, retire and the rename unit.
interface rename_map_lifo_if #(
  parameter int unsigned ARCH_REG_WIDTH = 5,
  parameter int unsigned PHYS_REG_WIDTH = 6
);
  logic                      rename_valid_i;
  logic                      rename_ready_o;
  logic [ARCH_REG_WIDTH-1:0] rename_rd_i;
  logic [ARCH_REG_WIDTH-1:0] rename_rs1_i;
  logic [ARCH_REG_WIDTH-1:0] rename_rs2_i;
  logic                      out_valid_o;
  logic [PHYS_REG_WIDTH-1:0] out_rd_o;
  logic [PHYS_REG_WIDTH-1:0] out_rs1_o;
  logic [PHYS_REG_WIDTH-1:0] out_rs2_o;
  logic [PHYS_REG_WIDTH-1:0] out_prev_rd_o;
  logic                      commit_valid_i;
  logic [ARCH_REG_WIDTH-1:0] commit_ard_i;
  logic [PHYS_REG_WIDTH-1:0] commit_prd_i;
  logic [PHYS_REG_WIDTH-1:0] commit_prev_prd_i;
  logic                      flush_i;
  logic [PHYS_REG_WIDTH-1:0] free_count_o;
  logic                      busy_o;

  modport master (
    output rename_valid_i, rename_rd_i, rename_rs1_i, rename_rs2_i,
    output commit_valid_i, commit_ard_i, commit_prd_i, commit_prev_prd_i, flush_i,
    input  rename_ready_o, out_valid_o, out_rd_o, out_rs1_o, out_rs2_o, out_prev_rd_o,
    input  free_count_o, busy_o
  );

  modport slave (
    input  rename_valid_i, rename_rd_i, rename_rs1_i, rename_rs2_i,
    input  commit_valid_i, commit_ard_i, commit_prd_i, commit_prev_prd_i, flush_i,
    output rename_ready_o, out_valid_o, out_rd_o, out_rs1_o, out_rs2_o, out_prev_rd_o,
    output free_count_o, busy_o
  );
endinterface

// File: rtl/rename_map_lifo.sv
// Register rename unit: speculative/committed RATs, LIFO free list, and a
// one-register-per-cycle free-list rebuild from the committed bitmap after flush.
module rename_map_lifo #(
  parameter int unsigned ARCH_REG_WIDTH = 5,
  parameter int unsigned PHYS_REG_WIDTH = 6
) (
  input logic              clk_i,
  input logic              rst_ni,
  rename_map_lifo_if.slave rn_io
);
  localparam int unsigned NumArch = 2 ** ARCH_REG_WIDTH;
  localparam int unsigned NumPhys = 2 ** PHYS_REG_WIDTH;

  typedef logic [PHYS_REG_WIDTH-1:0] preg_t;
  typedef enum logic [0:0] {StIdle, StRebuild} state_e;

  localparam preg_t MaxPhys = preg_t'(NumPhys - 1);
  localparam preg_t One     = preg_t'(1);

  state_e             r_state, w_state_next;
  preg_t              r_spec_rat [NumArch];
  preg_t              r_comm_rat [NumArch];
  logic [NumPhys-1:0] r_bitmap;
  preg_t              r_stack    [NumPhys];
  preg_t              r_count;
  preg_t              r_scan;
  logic               r_out_valid;
  preg_t              r_out_rd, r_out_rs1, r_out_rs2, r_out_prev;

  logic  w_idle, w_flush, w_ready, w_accept, w_pop, w_commit, w_push;
  preg_t w_top, w_prev;

  assign w_idle   = (r_state == StIdle);
  assign w_flush  = rn_io.flush_i;
  assign w_ready  = (r_count != '0) && w_idle && !w_flush;
  assign w_accept = rn_io.rename_valid_i && w_ready;
  assign w_pop    = w_accept && (rn_io.rename_rd_i != '0);
  // Commits are only honoured while idle; the push is dropped on flush or when full.
  assign w_commit = rn_io.commit_valid_i && w_idle && (rn_io.commit_ard_i != '0);
  assign w_prev   = rn_io.commit_prev_prd_i;
  assign w_push   = w_commit && !w_flush && (w_prev != '0) && (r_count != MaxPhys);
  assign w_top    = r_stack[r_count - One];

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (w_flush) w_state_next = StRebuild;
      StRebuild: if (!w_flush && (r_scan == One)) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumArch; i++) begin
        r_spec_rat[i] <= '0;
        r_comm_rat[i] <= '0;
      end
      r_bitmap <= '0;
      // Bottom of stack holds the highest register so that 1 ends up on top.
      for (int i = 0; i < NumPhys; i++) r_stack[i] <= preg_t'(NumPhys - 1 - i);
      r_count     <= MaxPhys;
      r_scan      <= '0;
      r_out_valid <= 1'b0;
      r_out_rd    <= '0;
      r_out_rs1   <= '0;
      r_out_rs2   <= '0;
      r_out_prev  <= '0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_out_rs1  <= r_spec_rat[rn_io.rename_rs1_i];
        r_out_rs2  <= r_spec_rat[rn_io.rename_rs2_i];
        r_out_rd   <= w_pop ? w_top : '0;
        r_out_prev <= w_pop ? r_spec_rat[rn_io.rename_rd_i] : '0;
      end

      if (w_commit) begin
        r_comm_rat[rn_io.commit_ard_i] <= rn_io.commit_prd_i;
        if (w_prev != '0)              r_bitmap[w_prev] <= 1'b0;
        if (rn_io.commit_prd_i != '0)  r_bitmap[rn_io.commit_prd_i] <= 1'b1;
      end

      if (w_flush) begin
        for (int i = 0; i < NumArch; i++) r_spec_rat[i] <= r_comm_rat[i];
        if (w_commit) r_spec_rat[rn_io.commit_ard_i] <= rn_io.commit_prd_i;
        r_count <= '0;
        r_scan  <= MaxPhys;
      end else if (!w_idle) begin
        if (!r_bitmap[r_scan]) begin
          r_stack[r_count] <= r_scan;
          r_count          <= r_count + One;
        end
        r_scan <= r_scan - One;
      end else begin
        if (w_pop) r_spec_rat[rn_io.rename_rd_i] <= w_top;
        // Shared pop/push: the pushed register lands in the slot just popped.
        if (w_pop && w_push) begin
          r_stack[r_count - One] <= w_prev;
        end else if (w_push) begin
          r_stack[r_count] <= w_prev;
          r_count          <= r_count + One;
        end else if (w_pop) begin
          r_count <= r_count - One;
        end
      end
    end
  end

  assign rn_io.rename_ready_o = w_ready;
  assign rn_io.out_valid_o    = r_out_valid;
  assign rn_io.out_rd_o       = r_out_rd;
  assign rn_io.out_rs1_o      = r_out_rs1;
  assign rn_io.out_rs2_o      = r_out_rs2;
  assign rn_io.out_prev_rd_o  = r_out_prev;
  assign rn_io.free_count_o   = r_count;
  assign rn_io.busy_o         = !w_idle;
endmodule
